// File: rtl/cache_refill_ctrl_if.sv
// Bus bundle for the cache refill controller: propagated cache requests,
// refilled block result and the single-word ack-handshaked RAM port.
interface cache_refill_ctrl_if #(
    parameter int RAM_ADDRESS_BITS = 32,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2
);
    logic [RAM_ADDRESS_BITS-1:0]          prop_address;
    logic                                 prop_read_en;
    logic [DATA_BITS-1:0]                 prop_write_data;
    logic                                 prop_write_en;
    logic [BLOCK_BITS-1:0][DATA_BITS-1:0] ram_data;
    logic                                 ram_valid;
    logic                                 busy;
    logic                                 mem_req;
    logic                                 mem_we;
    logic [RAM_ADDRESS_BITS-1:0]          mem_addr;
    logic [DATA_BITS-1:0]                 mem_wdata;
    logic                                 mem_ack;
    logic [DATA_BITS-1:0]                 mem_rdata;

    modport master (
        input  prop_address, prop_read_en, prop_write_data, prop_write_en,
        input  mem_ack, mem_rdata,
        output ram_data, ram_valid, busy,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output prop_address, prop_read_en, prop_write_data, prop_write_en,
        output mem_ack, mem_rdata,
        input  ram_data, ram_valid, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Memory-side sequencer for the cache: forwards write-through words and
// serves read misses as an aligned burst of BLOCK_BITS RAM beats.
module cache_refill_ctrl #(
    parameter int RAM_ADDRESS_BITS = 32,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    cache_refill_ctrl_if.master bus
);
    localparam int IDX_BITS = $clog2(BLOCK_BITS);
    localparam logic [IDX_BITS-1:0]         LAST_IDX   = IDX_BITS'(BLOCK_BITS - 1);
    localparam logic [RAM_ADDRESS_BITS-1:0] ALIGN_MASK = ~RAM_ADDRESS_BITS'(BLOCK_BITS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                               state_q;
    logic [IDX_BITS-1:0]                  idx_q;
    logic [RAM_ADDRESS_BITS-1:0]          base_q;
    logic                                 pend_rd_q;
    logic                                 mem_req_q;
    logic                                 mem_we_q;
    logic [RAM_ADDRESS_BITS-1:0]          mem_addr_q;
    logic [DATA_BITS-1:0]                 mem_wdata_q;
    logic [BLOCK_BITS-1:0][DATA_BITS-1:0] ram_data_q;
    logic                                 ram_valid_q;
    logic                                 busy_q;

    logic                                 beat_done_d;
    logic [RAM_ADDRESS_BITS-1:0]          prop_base_d;
    logic [IDX_BITS-1:0]                  idx_d;
    logic [RAM_ADDRESS_BITS-1:0]          next_addr_d;

    // base is block-aligned, so OR-ing in the beat index never carries
    assign beat_done_d = mem_req_q & bus.mem_ack;
    assign prop_base_d = bus.prop_address & ALIGN_MASK;
    assign idx_d       = idx_q + IDX_BITS'(1);
    assign next_addr_d = base_q | RAM_ADDRESS_BITS'(idx_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            pend_rd_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ram_data_q  <= '0;
            ram_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ram_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.prop_write_en) begin
                        state_q     <= WRITE;
                        busy_q      <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= bus.prop_address;
                        mem_wdata_q <= bus.prop_write_data;
                        pend_rd_q   <= bus.prop_read_en;
                        base_q      <= prop_base_d;
                    end else if (bus.prop_read_en) begin
                        state_q    <= READ;
                        busy_q     <= 1'b1;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= prop_base_d;
                        base_q     <= prop_base_d;
                        idx_q      <= '0;
                    end
                end
                WRITE: begin
                    if (beat_done_d) begin
                        mem_we_q <= 1'b0;
                        // a read requested alongside the write follows it with mem_req kept high
                        if (pend_rd_q) begin
                            pend_rd_q  <= 1'b0;
                            state_q    <= READ;
                            mem_addr_q <= base_q;
                            idx_q      <= '0;
                        end else begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (beat_done_d) begin
                        ram_data_q[idx_q] <= bus.mem_rdata;
                        if (idx_q == LAST_IDX) begin
                            state_q     <= DONE;
                            mem_req_q   <= 1'b0;
                            ram_valid_q <= 1'b1;
                        end else begin
                            idx_q      <= idx_d;
                            mem_addr_q <= next_addr_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_data  = ram_data_q;
    assign bus.ram_valid = ram_valid_q;
    assign bus.busy      = busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus pushes expected beats and
// blocks from a word-level memory model; a monitor pops them as the DUT acts.
module tb_cache_refill_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BB = 2;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } beat_t;
    typedef logic [BB-1:0][DW-1:0] blk_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    int unsigned n_vec = 0;
    int unsigned n_miss = 0;
    int unsigned wait_cycles = 0;
    int unsigned ack_cnt = 0;
    bit          noise_en = 1'b0;
    bit          prev_valid = 1'b0;
    beat_t       exp_beats[$];
    blk_t        exp_blks[$];
    beat_t       mon_e;
    blk_t        mon_b;
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [DW-1:0] ram_store [logic [AW-1:0]];

    cache_refill_ctrl_if #(.RAM_ADDRESS_BITS(AW), .DATA_BITS(DW), .BLOCK_BITS(BB)) bus ();

    cache_refill_ctrl #(.RAM_ADDRESS_BITS(AW), .DATA_BITS(DW), .BLOCK_BITS(BB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Unwritten RAM words read back as address*3; written words read back as stored.
    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return DW'(a * 3);
    endfunction

    // RAM responder: acks after wait_cycles idle cycles, random ack noise while no request
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            bus.mem_ack = 1'b0;
            ack_cnt = 0;
        end else if (bus.mem_req) begin
            if (ack_cnt >= wait_cycles) begin
                bus.mem_ack = 1'b1;
                ack_cnt = 0;
            end else begin
                bus.mem_ack = 1'b0;
                ack_cnt++;
            end
        end else begin
            bus.mem_ack = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            ack_cnt = 0;
        end
        bus.mem_rdata = ram_store.exists(bus.mem_addr) ? ram_store[bus.mem_addr]
                                                       : DW'(bus.mem_addr * 3);
    end

    // Monitor: every completing beat and every ram_valid pulse is matched against the queues
    always @(negedge clk) begin
        if (reset_n && bus.mem_req && bus.mem_ack) begin
            if (exp_beats.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_beat: got we=%0d addr=%h, required no beat",
                         bus.mem_we, bus.mem_addr);
            end else begin
                mon_e = exp_beats.pop_front();
                chk("beat_we", 64'(bus.mem_we), 64'(mon_e.we));
                chk("beat_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
                if (mon_e.we) chk("beat_wdata", 64'(bus.mem_wdata), 64'(mon_e.wdata));
            end
            if (bus.mem_we) ram_store[bus.mem_addr] = bus.mem_wdata;
        end
        if (reset_n && bus.ram_valid) begin
            chk("ram_valid_single_cycle", 64'(prev_valid), 0);
            chk("busy_with_valid", 64'(bus.busy), 1);
            if (exp_blks.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_valid: got ram_valid=1, required no block");
            end else begin
                mon_b = exp_blks.pop_front();
                for (int i = 0; i < BB; i++)
                    chk($sformatf("ram_data[%0d]", i), 64'(bus.ram_data[i]), 64'(mon_b[i]));
            end
        end
        prev_valid = bus.ram_valid;
    end

    task automatic issue(input bit wr, input bit rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit expect_it);
        @(negedge clk);
        if (expect_it) begin
            if (wr) begin
                exp_beats.push_back('{1'b1, a, d});
                model_mem[a] = d;
            end
            if (rd) begin
                blk_t          b;
                logic [AW-1:0] base;
                base = a - (a % AW'(BB));
                for (int i = 0; i < BB; i++) begin
                    exp_beats.push_back('{1'b0, base + AW'(i), '0});
                    b[i] = model_rd(base + AW'(i));
                end
                exp_blks.push_back(b);
            end
        end
        bus.prop_write_en   = wr;
        bus.prop_read_en    = rd;
        bus.prop_address    = a;
        bus.prop_write_data = d;
        @(negedge clk);
        bus.prop_write_en = 1'b0;
        bus.prop_read_en  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_timeout"}, 64'(bus.busy), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 0);
        chk({tag, "_ram_valid"}, 64'(bus.ram_valid), 0);
        chk({tag, "_mem_req"}, 64'(bus.mem_req), 0);
        chk({tag, "_mem_we"}, 64'(bus.mem_we), 0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 0);
        for (int i = 0; i < BB; i++)
            chk($sformatf("%s_ram_data[%0d]", tag, i), 64'(bus.ram_data[i]), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.prop_address    = '0;
        bus.prop_read_en    = 1'b0;
        bus.prop_write_data = '0;
        bus.prop_write_en   = 1'b0;
        bus.mem_ack         = 1'b0;
        bus.mem_rdata       = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        #2 reset_n = 1'b1;

        // read 0xB, ack tied high: beats 0xA,0xB, valid in the 3rd cycle after sampling
        wait_cycles = 0;
        issue(1'b0, 1'b1, 'hB, '0, 1'b1);
        chk("t2_busy", 64'(bus.busy), 1);
        chk("t2_valid_c1", 64'(bus.ram_valid), 0);
        @(negedge clk);
        chk("t2_valid_c2", 64'(bus.ram_valid), 0);
        @(negedge clk);
        chk("t2_valid_c3", 64'(bus.ram_valid), 1);
        @(negedge clk);
        chk("t2_valid_c4", 64'(bus.ram_valid), 0);
        chk("t2_busy_end", 64'(bus.busy), 0);

        // asynchronous reset while idle clears the refilled block
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_zero("mid_reset");
        @(negedge clk);
        #2 reset_n = 1'b1;

        // write with immediate ack is busy for exactly one cycle
        issue(1'b1, 1'b0, 'h100, 'h1234, 1'b1);
        chk("wr_busy_c1", 64'(bus.busy), 1);
        @(negedge clk);
        chk("wr_busy_c2", 64'(bus.busy), 0);

        // write with 3 wait cycles: beat held stable for 4 cycles
        wait_cycles = 3;
        issue(1'b1, 1'b0, 'h5001, 'hFAFA, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("t3_req", 64'(bus.mem_req), 1);
            chk("t3_we", 64'(bus.mem_we), 1);
            chk("t3_addr", 64'(bus.mem_addr), 'h5001);
            chk("t3_wdata", 64'(bus.mem_wdata), 'hFAFA);
            chk("t3_busy", 64'(bus.busy), 1);
            chk("t3_valid", 64'(bus.ram_valid), 0);
        end
        @(negedge clk);
        chk("t3_busy_end", 64'(bus.busy), 0);

        // simultaneous write and read: write beat first, then block read
        wait_cycles = 1;
        issue(1'b1, 1'b1, 'd10, 'h55, 1'b1);
        wait_idle("t4");

        // top-of-memory block; a read during the burst is dropped
        wait_cycles = 0;
        issue(1'b0, 1'b1, 'hFFFF_FFFF, '0, 1'b1);
        issue(1'b0, 1'b1, 'h20, '0, 1'b0);
        wait_idle("t5");
        repeat (3) @(negedge clk);
        chk("t5_no_extra_req", 64'(bus.mem_req), 0);

        // reset in the middle of the second read beat
        wait_cycles = 2;
        issue(1'b0, 1'b1, 'h30, '0, 1'b1);
        repeat (3) @(negedge clk);
        chk("t6_in_beat2_addr", 64'(bus.mem_addr), 'h31);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_req_cleared", 64'(bus.mem_req), 0);
        chk("t6_busy_cleared", 64'(bus.busy), 0);
        chk("t6_ram_data0_cleared", 64'(bus.ram_data[0]), 0);
        exp_beats.delete();
        exp_blks.delete();
        @(negedge clk);
        #2 reset_n = 1'b1;
        wait_cycles = 1;
        issue(1'b0, 1'b1, 'h4, '0, 1'b1);
        wait_idle("t6_after");

        noise_en = 1'b1;
        for (int t = 0; t < 60; t++) begin
            int unsigned   kind;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            kind = $urandom_range(0, 2);
            a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            d = DW'($urandom);
            wait_cycles = $urandom_range(0, 3);
            issue(kind != 1, kind != 0, a, d, 1'b1);
            wait_idle("rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("beats_outstanding", 64'(exp_beats.size()), 0);
        chk("blocks_outstanding", 64'(exp_blks.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
